// File: rtl/ascon_p_sequencer_if.sv
// Job-side handshake between the mode controller (master) and the
// Ascon permutation sequencer (slave).
interface ascon_p_sequencer_if #(
  parameter int BW = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [5*BW-1:0] s_in;
  logic [3:0]      num_rounds;
  logic            out_valid;
  logic            out_ready;
  logic [5*BW-1:0] out_state;

  modport master (
    output in_valid, s_in, num_rounds, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, s_in, num_rounds, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/ascon_p_sequencer.sv
// Iterative driver for a single-round Ascon permutation core. Applies the
// last a_eff round indices of 0..11 to a 320-bit state, one round every
// CORE_LAT+1 cycles, feeding each core result back as the next input.
module ascon_p_sequencer #(
  parameter int BW       = 64,
  parameter int CORE_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  ascon_p_sequencer_if.slave   job,
  output logic                 busy,
  output logic [3:0]           core_round,
  output logic [5*BW-1:0]      core_s_in,
  input  logic [5*BW-1:0]      core_s_out
);

  localparam int PH_W = (CORE_LAT > 0) ? $clog2(CORE_LAT + 1) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CORE_LAT);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [5*BW-1:0] st_reg;
  logic [3:0]      rnd_idx;
  logic [3:0]      rnd_cnt;
  logic [3:0]      a_eff;
  logic [PH_W-1:0] ph_cnt;
  logic            accept;
  logic            round_end;

  // Round count saturates at 12 (full p12)
  always_comb a_eff = (job.num_rounds > 4'd12) ? 4'd12 : job.num_rounds;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and handshake/status outputs
  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    round_end     = 1'b0;
    job.in_ready  = 1'b0;
    job.out_valid = 1'b0;
    busy          = 1'b0;
    case (state)
      IDLE: begin
        job.in_ready = 1'b1;
        if (job.in_valid) begin
          accept    = 1'b1;
          state_nxt = (a_eff == 4'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (ph_cnt == PH_LAST) begin
          round_end = 1'b1;
          if (rnd_cnt == 4'd1) state_nxt = DONE;
        end
      end
      DONE: begin
        job.out_valid = 1'b1;
        if (job.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Working state, round index/count and per-round phase counter
  always_ff @(posedge clk) begin
    if (rst) begin
      st_reg  <= '0;
      rnd_idx <= '0;
      rnd_cnt <= '0;
      ph_cnt  <= '0;
    end else if (accept) begin
      st_reg  <= job.s_in;
      rnd_cnt <= a_eff;
      ph_cnt  <= '0;
      // Pass-through jobs keep the old index so core_round never reads 12
      if (a_eff != 4'd0) rnd_idx <= 4'd12 - a_eff;
    end else if (state == RUN) begin
      if (round_end) begin
        st_reg  <= core_s_out;
        rnd_cnt <= rnd_cnt - 4'd1;
        ph_cnt  <= '0;
        // Index stops at 11 after the last round instead of wrapping to 12
        if (rnd_cnt != 4'd1) rnd_idx <= rnd_idx + 4'd1;
      end else begin
        ph_cnt <= ph_cnt + PH_W'(1);
      end
    end
  end

  // Core inputs and result are straight views of the working state
  always_comb begin
    core_s_in     = st_reg;
    core_round    = rnd_idx;
    job.out_state = st_reg;
  end

endmodule
